// File: rtl/matu_feeder.sv
// Upstream feeder for matu: assembles element-serial activation and weight/bias streams
// into tiles and presents them, with the current weight set, on a registered valid/ready port.
module matu_feeder #(
   parameter int unsigned INA_ROWS = 3,
   parameter int unsigned INA_COLS = 9,
   parameter int unsigned INB_ROWS = 1,
   parameter int unsigned INB_COLS = 9,
   parameter int unsigned IN_WIDTH = 8
) (
   input  logic                                             i_clk,
   input  logic                                             i_rst,
   input  logic                                             i_act_valid,
   output logic                                             o_act_ready,
   input  logic [IN_WIDTH-1:0]                              i_act_data,
   input  logic                                             i_wgt_valid,
   output logic                                             o_wgt_ready,
   input  logic [IN_WIDTH-1:0]                              i_wgt_data,
   input  logic                                             i_wgt_flush,
   output logic                                             o_post_valid,
   input  logic                                             i_post_ready,
   output logic [INA_ROWS-1:0][INA_COLS-1:0][IN_WIDTH-1:0]  o_a,
   output logic [INB_ROWS-1:0][INB_COLS-1:0][IN_WIDTH-1:0]  o_b,
   output logic [INB_ROWS-1:0][IN_WIDTH-1:0]                o_d
);

   localparam int unsigned NA  = INA_ROWS * INA_COLS;
   localparam int unsigned NB  = INB_ROWS * INB_COLS;
   localparam int unsigned NW  = NB + INB_ROWS;
   localparam int unsigned ACW = (NA > 1) ? $clog2(NA) : 1;
   localparam int unsigned WCW = (NW > 1) ? $clog2(NW) : 1;

   logic [ACW-1:0]                act_cnt_q, act_cnt_d;
   logic                          act_full_q, act_full_d;
   logic [NA-1:0][IN_WIDTH-1:0]   act_mem_q, act_mem_d;

   logic [WCW-1:0]                wgt_cnt_q, wgt_cnt_d;
   logic                          wgt_full_q, wgt_full_d;
   logic [NW-1:0][IN_WIDTH-1:0]   wgt_mem_q, wgt_mem_d;

   logic                                             post_valid_q, post_valid_d;
   logic [INA_ROWS-1:0][INA_COLS-1:0][IN_WIDTH-1:0]  a_q, a_d;
   logic [INB_ROWS-1:0][INB_COLS-1:0][IN_WIDTH-1:0]  b_q, b_d;
   logic [INB_ROWS-1:0][IN_WIDTH-1:0]                d_q, d_d;

   logic act_hs;
   logic wgt_hs;
   logic post_hs;
   logic xfer;

   // Readies come from registered state only, so i_post_ready never reaches them.
   assign o_act_ready = !act_full_q && !i_rst;
   assign o_wgt_ready = !wgt_full_q && !i_rst;

   assign act_hs  = i_act_valid && o_act_ready;
   assign wgt_hs  = i_wgt_valid && o_wgt_ready && !i_wgt_flush;
   assign post_hs = post_valid_q && i_post_ready;
   assign xfer    = act_full_q && wgt_full_q && (!post_valid_q || i_post_ready);

   always_comb begin
      act_cnt_d  = act_cnt_q;
      act_full_d = act_full_q;
      act_mem_d  = act_mem_q;
      if (act_hs) begin
         act_mem_d[act_cnt_q] = i_act_data;
         if (act_cnt_q == ACW'(NA - 1)) begin
            act_full_d = 1'b1;
            act_cnt_d  = '0;
         end else begin
            act_cnt_d = act_cnt_q + 1'b1;
         end
      end
      if (xfer) begin
         act_full_d = 1'b0;
      end
   end

   always_comb begin
      wgt_cnt_d  = wgt_cnt_q;
      wgt_full_d = wgt_full_q;
      wgt_mem_d  = wgt_mem_q;
      if (wgt_hs) begin
         wgt_mem_d[wgt_cnt_q] = i_wgt_data;
         if (wgt_cnt_q == WCW'(NW - 1)) begin
            wgt_full_d = 1'b1;
            wgt_cnt_d  = '0;
         end else begin
            wgt_cnt_d = wgt_cnt_q + 1'b1;
         end
      end
      // A flush coinciding with xfer still lets this cycle's copy see the old weights.
      if (i_wgt_flush) begin
         wgt_full_d = 1'b0;
         wgt_cnt_d  = '0;
      end
   end

   always_comb begin
      post_valid_d = post_valid_q;
      a_d          = a_q;
      b_d          = b_q;
      d_d          = d_q;
      if (xfer) begin
         post_valid_d = 1'b1;
         a_d          = act_mem_q;
         b_d          = wgt_mem_q[NB-1:0];
         d_d          = wgt_mem_q[NW-1:NB];
      end else if (post_hs) begin
         post_valid_d = 1'b0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         act_cnt_q    <= '0;
         act_full_q   <= 1'b0;
         wgt_cnt_q    <= '0;
         wgt_full_q   <= 1'b0;
         post_valid_q <= 1'b0;
         a_q          <= '0;
         b_q          <= '0;
         d_q          <= '0;
      end else begin
         act_cnt_q    <= act_cnt_d;
         act_full_q   <= act_full_d;
         wgt_cnt_q    <= wgt_cnt_d;
         wgt_full_q   <= wgt_full_d;
         post_valid_q <= post_valid_d;
         a_q          <= a_d;
         b_q          <= b_d;
         d_q          <= d_d;
      end
   end

   // Bank storage is qualified by the full flags, so it needs no reset.
   always_ff @(posedge i_clk) begin
      act_mem_q <= act_mem_d;
      wgt_mem_q <= wgt_mem_d;
   end

   assign o_post_valid = post_valid_q;
   assign o_a          = a_q;
   assign o_b          = b_q;
   assign o_d          = d_q;

endmodule

// File: tb/tb_matu_feeder.sv
// Scoreboard bench for matu_feeder: directed streams, expected tiles queued at issue time
// and compared by an independent monitor on every output handshake.
module tb_matu_feeder;

   localparam int R  = 3;
   localparam int C  = 9;
   localparam int BR = 1;
   localparam int BC = 9;
   localparam int W  = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                           i_rst = 1'b1;
   logic                           i_act_valid = 1'b0;
   logic                           o_act_ready;
   logic [W-1:0]                   i_act_data = '0;
   logic                           i_wgt_valid = 1'b0;
   logic                           o_wgt_ready;
   logic [W-1:0]                   i_wgt_data = '0;
   logic                           i_wgt_flush = 1'b0;
   logic                           o_post_valid;
   logic                           i_post_ready = 1'b1;
   logic [R-1:0][C-1:0][W-1:0]     o_a;
   logic [BR-1:0][BC-1:0][W-1:0]   o_b;
   logic [BR-1:0][W-1:0]           o_d;

   matu_feeder #(
      .INA_ROWS(R),
      .INA_COLS(C),
      .INB_ROWS(BR),
      .INB_COLS(BC),
      .IN_WIDTH(W)
   ) dut (
      .i_clk       (clk),
      .i_rst       (i_rst),
      .i_act_valid (i_act_valid),
      .o_act_ready (o_act_ready),
      .i_act_data  (i_act_data),
      .i_wgt_valid (i_wgt_valid),
      .o_wgt_ready (o_wgt_ready),
      .i_wgt_data  (i_wgt_data),
      .i_wgt_flush (i_wgt_flush),
      .o_post_valid(o_post_valid),
      .i_post_ready(i_post_ready),
      .o_a         (o_a),
      .o_b         (o_b),
      .o_d         (o_d)
   );

   typedef struct packed {
      logic [R-1:0][C-1:0][W-1:0]   a;
      logic [BR-1:0][BC-1:0][W-1:0] b;
      logic [BR-1:0][W-1:0]         d;
   } tile_t;

   tile_t exp_q[$];
   tile_t mon_got;
   tile_t mon_exp;
   tile_t snap;
   logic  watch = 1'b0;
   logic  stable_bad = 1'b0;
   int    checks = 0;
   int    failures = 0;

   function automatic tile_t mk(input int ab, input int wb, input int bias);
      tile_t t;
      t = '0;
      for (int k = 0; k < R * C; k++) t.a[k / C][k % C] = 8'(ab + k);
      for (int k = 0; k < BC; k++) t.b[0][k] = 8'(wb + k);
      t.d[0] = 8'(bias);
      return t;
   endfunction

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
      checks++;
      if (got !== req) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, got, req);
      end
   endtask

   // Monitor: every output handshake must match the oldest expected tile.
   always @(negedge clk) begin
      if (!i_rst && o_post_valid && i_post_ready) begin
         mon_got = {o_a, o_b, o_d};
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL sb_unexpected: tile a00=%0h presented with empty queue", o_a[0][0]);
         end else begin
            mon_exp = exp_q.pop_front();
            if (mon_got !== mon_exp) begin
               failures++;
               $display("FAIL sb_tile: got %h expected %h", mon_got, mon_exp);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (watch && (({o_a, o_b, o_d} !== snap) || !o_post_valid)) stable_bad = 1'b1;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic act_beat(input logic [W-1:0] v);
      int n;
      n = 0;
      i_act_valid = 1'b1;
      i_act_data  = v;
      @(negedge clk);
      while (!o_act_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) check("act_beat_timeout", 64'(o_act_ready), 64'd1);
      step();
      i_act_valid = 1'b0;
   endtask

   task automatic wgt_beat(input logic [W-1:0] v);
      int n;
      n = 0;
      i_wgt_valid = 1'b1;
      i_wgt_data  = v;
      @(negedge clk);
      while (!o_wgt_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) check("wgt_beat_timeout", 64'(o_wgt_ready), 64'd1);
      step();
      i_wgt_valid = 1'b0;
   endtask

   task automatic act_stream(input int ab, input int cnt);
      for (int k = 0; k < cnt; k++) act_beat(8'(ab + k));
   endtask

   task automatic wgt_set(input int wb, input int bias);
      for (int k = 0; k < BC; k++) wgt_beat(8'(wb + k));
      wgt_beat(8'(bias));
   endtask

   task automatic flush_pulse();
      i_wgt_flush = 1'b1;
      step();
      i_wgt_flush = 1'b0;
   endtask

   task automatic wait_valid(input string name, input int limit);
      int n;
      n = 0;
      @(negedge clk);
      while (!o_post_valid && n < limit) begin
         @(negedge clk);
         n++;
      end
      check(name, 64'(o_post_valid), 64'd1);
      step();
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         step();
         n++;
      end
      check(name, 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      // Reset state
      repeat (3) step();
      mid();
      check("rst_act_ready", 64'(o_act_ready), 64'd0);
      check("rst_wgt_ready", 64'(o_wgt_ready), 64'd0);
      check("rst_valid", 64'(o_post_valid), 64'd0);
      check("rst_o_a", 64'(|o_a), 64'd0);
      step();
      i_rst = 1'b0;
      mid();
      check("post_rst_act_ready", 64'(o_act_ready), 64'd1);
      check("post_rst_wgt_ready", 64'(o_wgt_ready), 64'd1);
      step();

      // 1: basic tile, latency of two cycles after the last activation beat
      wgt_set(1, 5);
      exp_q.push_back(mk(1, 1, 5));
      act_stream(1, 27);
      mid();
      check("t1_valid_t1", 64'(o_post_valid), 64'd0);
      step();
      mid();
      check("t1_valid_t2", 64'(o_post_valid), 64'd1);
      check("t1_a00", 64'(o_a[0][0]), 64'd1);
      check("t1_a28", 64'(o_a[2][8]), 64'd27);
      check("t1_d0", 64'(o_d[0]), 64'd5);
      step();
      mid();
      check("t1_valid_one_cycle", 64'(o_post_valid), 64'd0);
      step();

      // 2: stall with next tile loaded behind it, then back-to-back presentation
      i_post_ready = 1'b0;
      exp_q.push_back(mk(41, 1, 5));
      act_stream(41, 27);
      wait_valid("t2_tileA_valid", 20);
      snap  = {o_a, o_b, o_d};
      watch = 1'b1;
      exp_q.push_back(mk(101, 1, 5));
      act_stream(101, 27);
      mid();
      check("t2_act_ready_low", 64'(o_act_ready), 64'd0);
      step();
      repeat (10) step();
      watch = 1'b0;
      check("t2_stable", 64'(stable_bad), 64'd0);
      i_post_ready = 1'b1;
      mid();
      step();
      i_post_ready = 1'b0;
      mid();
      check("t2_b2b_valid", 64'(o_post_valid), 64'd1);
      check("t2_b2b_a00", 64'(o_a[0][0]), 64'd101);
      step();
      i_post_ready = 1'b1;
      drain("t2_drain");

      // 3: activations without weights stall until weights arrive
      flush_pulse();
      act_stream(201, 27);
      repeat (5) step();
      mid();
      check("t3_no_valid", 64'(o_post_valid), 64'd0);
      check("t3_act_ready_low", 64'(o_act_ready), 64'd0);
      step();
      exp_q.push_back(mk(201, 21, 9));
      wgt_set(21, 9);
      mid();
      check("t3_valid_t1", 64'(o_post_valid), 64'd0);
      step();
      mid();
      check("t3_valid_t2", 64'(o_post_valid), 64'd1);
      step();
      drain("t3_drain");

      // 4: flush discards a partial weight load
      flush_pulse();
      for (int k = 0; k < 4; k++) wgt_beat(8'(90 + k));
      flush_pulse();
      wgt_set(11, 7);
      exp_q.push_back(mk(151, 11, 7));
      act_stream(151, 27);
      wait_valid("t4_valid", 20);
      check("t4_b00", 64'(o_b[0][0]), 64'd11);
      check("t4_d0", 64'(o_d[0]), 64'd7);
      drain("t4_drain");

      // 5: flush in the xfer cycle; tile keeps old weights, next bank stalls
      exp_q.push_back(mk(171, 11, 7));
      act_stream(171, 27);
      flush_pulse();
      mid();
      check("t5_valid", 64'(o_post_valid), 64'd1);
      check("t5_old_b00", 64'(o_b[0][0]), 64'd11);
      step();
      mid();
      check("t5_wgt_ready", 64'(o_wgt_ready), 64'd1);
      step();
      act_stream(181, 27);
      repeat (8) step();
      mid();
      check("t5_stall_no_valid", 64'(o_post_valid), 64'd0);
      check("t5_stall_act_ready", 64'(o_act_ready), 64'd0);
      step();
      exp_q.push_back(mk(181, 61, 3));
      wgt_set(61, 3);
      wait_valid("t5_reload_valid", 20);
      drain("t5_drain");

      // 6: reset while presenting with a half-full bank
      i_post_ready = 1'b0;
      act_stream(1, 27);
      wait_valid("t6_pre_valid", 20);
      act_stream(31, 13);
      i_rst = 1'b1;
      mid();
      check("t6_rst_act_ready", 64'(o_act_ready), 64'd0);
      check("t6_rst_wgt_ready", 64'(o_wgt_ready), 64'd0);
      step();
      i_rst = 1'b0;
      mid();
      check("t6_valid_cleared", 64'(o_post_valid), 64'd0);
      check("t6_o_a_zero", 64'(|o_a), 64'd0);
      check("t6_o_b_zero", 64'(|o_b), 64'd0);
      check("t6_o_d_zero", 64'(|o_d), 64'd0);
      step();
      i_post_ready = 1'b1;
      act_stream(211, 27);
      repeat (5) step();
      mid();
      check("t6_no_weights", 64'(o_post_valid), 64'd0);
      step();
      exp_q.push_back(mk(211, 71, 4));
      wgt_set(71, 4);
      wait_valid("t6_new_valid", 20);
      drain("t6_drain");

      repeat (5) step();
      check("final_queue_empty", 64'(exp_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/matu_feeder.md
# matu_feeder

Upstream feeder that drives the `matu` input handshake.
- Accepts two element-serial streams:
  - an activation stream, assembled into one `INA_ROWS x INA_COLS` tile per transfer;
  - a weight/bias stream, assembled into a persistent `INB_ROWS x INB_COLS` weight set plus `INB_ROWS` biases.
- Presents each complete tile with the current weights on a valid/ready port that connects directly to `matu` (`o_post_valid`→`i_pre_valid`, `i_post_ready`←`o_pre_ready`, `o_a`/`o_b`/`o_d`→`i_a`/`i_b`/`i_d`).
- An output register stage lets the next tile load while the current one waits.

## Interface
Parameters:
- `INA_ROWS`, 3, activation tile rows.
- `INA_COLS`, 9, activation tile columns.
- `INB_ROWS`, 1, weight rows (also the bias count).
- `INB_COLS`, 9, weight columns.
- `IN_WIDTH`, 8, element width.

Ports (one clock; reset is synchronous and active-high):
- `i_clk` in 1: clock.
- `i_rst` in 1: synchronous active-high reset.
- `i_act_valid` in 1: activation beat valid.
- `o_act_ready` out 1: activation beat accepted when high together with `i_act_valid`.
- `i_act_data` in `IN_WIDTH`: activation element.
- `i_wgt_valid` in 1: weight/bias beat valid.
- `o_wgt_ready` out 1: weight beat accepted when high together with `i_wgt_valid`.
- `i_wgt_data` in `IN_WIDTH`: weight or bias element.
- `i_wgt_flush` in 1: one-cycle pulse that invalidates the loaded weight set.
- `o_post_valid` out 1: tile presented.
- `i_post_ready` in 1: downstream accepts the tile.
- `o_a` out `[INA_ROWS-1:0][INA_COLS-1:0]` x `IN_WIDTH`: activation tile.
- `o_b` out `[INB_ROWS-1:0][INB_COLS-1:0]` x `IN_WIDTH`: weights.
- `o_d` out `[INB_ROWS-1:0]` x `IN_WIDTH`: biases.

## Operation
Activation bank:
- Counter `act_cnt` runs over 0..NA-1, where NA = `INA_ROWS*INA_COLS`.
- Beat k writes `a[k/INA_COLS][k%INA_COLS]` (row-major).
- On the beat with k = NA-1: set `act_full`; clear `act_cnt`.
- `o_act_ready = !act_full && !i_rst`.

Weight bank:
- Counter `wgt_cnt` runs over 0..NW-1, where NW = `INB_ROWS*INB_COLS + INB_ROWS`.
- Beats 0..`INB_ROWS*INB_COLS`-1 fill `b` row-major; the remaining `INB_ROWS` beats fill `d[0..]`.
- The last beat sets `wgt_full`.
- `o_wgt_ready = !wgt_full && !i_rst`.
- Weights stay loaded and are reused for every tile until flushed.

Flush (`i_wgt_flush`):
- Clears `wgt_full` and `wgt_cnt`, discarding a partial load.
- A weight beat handshaked in the same cycle is dropped; flush wins.

Transfer:
- `xfer = act_full && wgt_full && (!o_post_valid || i_post_ready)`.
- On `xfer`: copy the a/b/d banks into `o_a`/`o_b`/`o_d`, set `o_post_valid`, clear `act_full`.
- On a handshake (`o_post_valid && i_post_ready`) without `xfer`: clear `o_post_valid`.
- `xfer` together with flush in the same cycle: the copied tile carries the old weights, and the flush takes effect afterward.

Output stability: while `o_post_valid && !i_post_ready`, `o_a`/`o_b`/`o_d`/`o_post_valid` are held constant.

Reset:
- `act_cnt`, `wgt_cnt`, `act_full`, `wgt_full`, `o_post_valid` = 0.
- `o_a`/`o_b`/`o_d` = 0.
- Both readies are 0 during reset and 1 in the first cycle after it.
- Reset mid-tile discards all partial and presented data.

## Timing
- Last activation beat handshaked in cycle t, weights already loaded: `xfer` in t+1, `o_post_valid` high in t+2.
- Same rule for the last weight beat when the activation bank is already full: `o_post_valid` high 2 cycles later.
- `o_act_ready` is low for exactly one cycle after the bank fills when the output stage is free. Sustained throughput is one tile per NA+1 cycles.
- Back-to-back: if `act_full` is set and `o_post_valid && i_post_ready` in cycle t, the next tile is presented in t+1 with no valid gap.
- No combinational path from `i_post_ready` to `o_act_ready`/`o_wgt_ready`. `xfer` may depend combinationally on `i_post_ready`.

## Test plan
1. Reset, then send weights 1..9, bias 5, activations 1..27 with `i_post_ready`=1. Expect `o_post_valid` 2 cycles after the 27th beat; `o_a[0][0]`=1, `o_a[2][8]`=27, `o_b[0][k]`=k+1, `o_d[0]`=5; valid for one cycle.
2. Hold `i_post_ready`=0 for 40 cycles after tile 1 and stream activations 101..127.
   - Tile 1 outputs stay constant.
   - `o_act_ready` falls after 27 accepted beats.
   - One `i_post_ready` pulse makes tile 2 (`o_a[0][0]`=101) appear the next cycle with `o_post_valid` continuously high.
3. Send all 27 activations with no weights. Expect no `o_post_valid` and `o_act_ready`=0. Completing 10 weight beats yields `o_post_valid` 2 cycles after the last weight beat.
4. After 4 weight beats, pulse `i_wgt_flush`, then send weights 11..19 and bias 7. Expect the emitted tile to show `o_b[0][0]`=11 and `o_d[0]`=7, with no trace of the partial load.
5. Assert flush in the same cycle as `xfer`. The emitted tile has the old weights. The next full activation bank stalls (no valid) until a new 10-beat weight set is loaded.
6. Assert `i_rst` for one cycle while `o_post_valid`=1 and the activation bank is half full. The next cycle shows `o_post_valid`=0 and outputs 0. A new tile then needs all 27 activations and 10 weight beats again.
